// File: rtl/ppu_write_scheduler_if.sv
// ppu_write_scheduler_if
//   Bundles the CPU S-type write request, the renderer read request and the
//   shared PPU memory port seen by ppu_write_scheduler.
//   slave  : the scheduler (consumes requests, drives the memory port/status)
//   master : the environment (CPU, renderer, memory-side observer)
// Signals:
//   PPU_en, S_type_index, S_type_value  CPU write request
//   cpu_stall                           FIFO full, CPU must hold
//   vblank, render_req, render_addr     renderer window and read request
//   render_grant                        render read performed this cycle
//   mem_addr, mem_wdata, mem_we         registered PPU memory port
//   fifo_count, overflow                buffer occupancy / sticky drop flag
interface ppu_write_scheduler_if #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              PPU_en;
    logic [ADDR_W-1:0] S_type_index;
    logic [DATA_W-1:0] S_type_value;
    logic              cpu_stall;
    logic              vblank;
    logic              render_req;
    logic [ADDR_W-1:0] render_addr;
    logic              render_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport slave (
        input  PPU_en, S_type_index, S_type_value, vblank, render_req, render_addr,
        output cpu_stall, render_grant, mem_addr, mem_wdata, mem_we, fifo_count, overflow
    );

    modport master (
        output PPU_en, S_type_index, S_type_value, vblank, render_req, render_addr,
        input  cpu_stall, render_grant, mem_addr, mem_wdata, mem_we, fifo_count, overflow
    );
endinterface

// File: rtl/ppu_write_scheduler.sv
// ppu_write_scheduler
//   Owns the single PPU memory port. CPU S-type writes are buffered in a FIFO
//   and drained into PPU memory during vblank, or outside vblank when the FIFO
//   reaches the high-water mark and the renderer can be held off briefly.
//   The renderer otherwise gets the port whenever it asks.
// Ports:
//   clk_100mhz  system clock, rising edge
//   rst_in      synchronous active-high reset
//   bus         ppu_write_scheduler_if.slave (CPU request, renderer request,
//               memory port, occupancy and overflow status)
module ppu_write_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int HIGH_WATER = 12,
    parameter int BURST_MAX  = 4
) (
    input  logic clk_100mhz,
    input  logic rst_in,
    ppu_write_scheduler_if.slave bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BURST_W-1:0] burst;

    logic full;
    logic empty;
    logic above_hw;
    logic burst_ok;
    logic push;
    logic pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign above_hw = (count >= CNT_W'(HIGH_WATER));
    assign burst_ok = (burst < BURST_W'(BURST_MAX));
    // Full is judged on the current count, so a same-cycle pop never frees a slot.
    assign push     = bus.PPU_en && !full;
    assign pop      = (state_next == DRAIN);

    assign bus.cpu_stall  = full;
    assign bus.fifo_count = count;

    // Port owner for the next cycle; first matching rule wins.
    always_comb begin
        state_next = IDLE;
        if (bus.vblank) begin
            if (!empty) begin
                state_next = DRAIN;
            end else if (bus.render_req) begin
                state_next = RENDER;
            end
        end else begin
            if (bus.render_req && !(above_hw && burst_ok && state == DRAIN)) begin
                state_next = RENDER;
            end else if (above_hw && !bus.render_req) begin
                state_next = DRAIN;
            end else if (above_hw && state == DRAIN && burst_ok) begin
                state_next = DRAIN;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            burst            <= '0;
            bus.mem_we       <= 1'b0;
            bus.render_grant <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            state <= state_next;

            if (bus.PPU_en && full) begin
                bus.overflow <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            unique case (state_next)
                DRAIN: begin
                    bus.mem_addr     <= fifo_addr[rd_ptr];
                    bus.mem_wdata    <= fifo_data[rd_ptr];
                    bus.mem_we       <= 1'b1;
                    bus.render_grant <= 1'b0;
                    // Saturates at BURST_MAX: an unbounded drain with no render
                    // request must not wrap the counter and re-open the burst.
                    if (bus.vblank) begin
                        burst <= '0;
                    end else if (burst_ok) begin
                        burst <= burst + 1'b1;
                    end
                end
                RENDER: begin
                    bus.mem_addr     <= bus.render_addr;
                    bus.mem_we       <= 1'b0;
                    bus.render_grant <= 1'b1;
                    burst            <= '0;
                end
                default: begin
                    bus.mem_we       <= 1'b0;
                    bus.render_grant <= 1'b0;
                    burst            <= '0;
                end
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.S_type_index;
            fifo_data[wr_ptr] <= bus.S_type_value;
        end
    end
endmodule

// File: tb/tb_ppu_write_scheduler.sv
// tb_ppu_write_scheduler
//   Directed stimulus for ppu_write_scheduler. Every accepted CPU write is
//   pushed into an expected-write queue; a negedge monitor pops and compares
//   whenever mem_we is high, and checks the address of every render grant.
module tb_ppu_write_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ppu_write_scheduler_if #(.ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(16)) bus ();

    ppu_write_scheduler #(
        .FIFO_DEPTH(16),
        .ADDR_W(10),
        .DATA_W(16),
        .HIGH_WATER(12),
        .BURST_MAX(4)
    ) dut (
        .clk_100mhz(clk),
        .rst_in(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;
    int gr_seen  = 0;
    int neg_seen = 0;
    logic [25:0] exp_q[$];
    logic [25:0] exp_e;
    logic [9:0]  exp_raddr = 10'h100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard for memory writes, address check for render grants.
    always @(negedge clk) begin
        neg_seen++;
        if (bus.mem_we === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(exp_e[25:16]));
                chk("wr_data", 32'(bus.mem_wdata), 32'(exp_e[15:0]));
            end
            chk("no_grant_on_write", 32'(bus.render_grant), 32'd0);
        end
        if (bus.render_grant === 1'b1) begin
            gr_seen++;
            chk("grant_addr", 32'(bus.mem_addr), 32'(exp_raddr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] a, input logic [15:0] d, input bit accept);
        bus.PPU_en       = 1'b1;
        bus.S_type_index = a;
        bus.S_type_value = d;
        if (accept) exp_q.push_back({a, d});
        tick();
        bus.PPU_en = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int limit);
        int n;
        n = 0;
        while (bus.fifo_count != '0 && n < limit) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.fifo_count), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int g0;
        int n0;
        int n;

        bus.PPU_en       = 1'b0;
        bus.S_type_index = '0;
        bus.S_type_value = '0;
        bus.vblank       = 1'b0;
        bus.render_req   = 1'b0;
        bus.render_addr  = 10'h100;

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_grant", 32'(bus.render_grant), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);

        // Vblank drain, two-edge latency, simultaneous push/pop
        bus.vblank = 1'b1;
        w0 = wr_seen;
        push(10'h005, 16'hABCD, 1'b1);
        chk("vb_lat_we0", 32'(bus.mem_we), 32'd0);
        chk("vb_count1", 32'(bus.fifo_count), 32'd1);
        push(10'h006, 16'h1234, 1'b1);
        chk("vb_we1", 32'(bus.mem_we), 32'd1);
        chk("vb_addr1", 32'(bus.mem_addr), 32'h005);
        chk("vb_pushpop_count", 32'(bus.fifo_count), 32'd1);
        tick();
        chk("vb_addr2", 32'(bus.mem_addr), 32'h006);
        chk("vb_count0", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("vb_we_off", 32'(bus.mem_we), 32'd0);
        chk("vb_writes", 32'(wr_seen - w0), 32'd2);

        // Render priority outside vblank
        bus.vblank      = 1'b0;
        bus.render_req  = 1'b1;
        bus.render_addr = 10'h100;
        exp_raddr       = 10'h100;
        tick();
        w0 = wr_seen;
        g0 = gr_seen;
        n0 = neg_seen;
        for (int i = 0; i < 3; i++) push(10'h010 + 10'(i), 16'h1000 + 16'(i), 1'b1);
        tick();
        chk("rp_grant_each_cycle", 32'(gr_seen - g0), 32'(neg_seen - n0));
        chk("rp_cycles", 32'(neg_seen - n0), 32'd4);
        chk("rp_no_writes", 32'(wr_seen - w0), 32'd0);
        chk("rp_count", 32'(bus.fifo_count), 32'd3);

        // High-water burst: fill to 16, one cycle without render_req
        for (int i = 0; i < 13; i++) push(10'h020 + 10'(i), 16'h2000 + 16'(i), 1'b1);
        chk("hw_count_full", 32'(bus.fifo_count), 32'd16);
        chk("hw_stall", 32'(bus.cpu_stall), 32'd1);
        chk("hw_no_writes", 32'(wr_seen - w0), 32'd0);
        w0 = wr_seen;
        bus.render_req = 1'b0;
        tick();
        bus.render_req = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("hw_burst_writes", 32'(wr_seen - w0), 32'd4);
        chk("hw_count_after", 32'(bus.fifo_count), 32'd12);
        chk("hw_grant_resumed", 32'(bus.render_grant), 32'd1);
        chk("hw_stall_off", 32'(bus.cpu_stall), 32'd0);

        // Drain the rest on vblank, in order
        bus.vblank = 1'b1;
        wait_empty("hw_vb_empty", 40);
        chk("hw_queue_done", 32'(exp_q.size()), 32'd0);

        // Full / overflow
        rst = 1'b1;
        tick();
        bus.vblank      = 1'b0;
        bus.render_addr = 10'h155;
        exp_raddr       = 10'h155;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) push(10'h300 + 10'(i), 16'h5A00 + 16'(i), 1'b1);
        chk("of_count16", 32'(bus.fifo_count), 32'd16);
        chk("of_stall", 32'(bus.cpu_stall), 32'd1);
        chk("of_not_yet", 32'(bus.overflow), 32'd0);
        push(10'h3FF, 16'hDEAD, 1'b0);
        chk("of_set", 32'(bus.overflow), 32'd1);
        chk("of_count_held", 32'(bus.fifo_count), 32'd16);
        w0 = wr_seen;
        bus.vblank = 1'b1;
        wait_empty("of_vb_empty", 40);
        chk("of_writes16", 32'(wr_seen - w0), 32'd16);
        chk("of_queue_done", 32'(exp_q.size()), 32'd0);
        chk("of_sticky", 32'(bus.overflow), 32'd1);

        // Reset mid-drain
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.vblank     = 1'b0;
        bus.render_req = 1'b0;
        for (int i = 0; i < 10; i++) push(10'h040 + 10'(i), 16'h7700 + 16'(i), 1'b1);
        chk("md_count10", 32'(bus.fifo_count), 32'd10);
        w0 = wr_seen;
        bus.vblank = 1'b1;
        n = 0;
        while (wr_seen < w0 + 3 && n < 30) begin
            tick();
            n++;
        end
        chk("md_three_writes", 32'(wr_seen - w0), 32'd3);
        rst = 1'b1;
        w0 = wr_seen;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) tick();
        chk("md_at_most_one", 32'((wr_seen - w0) <= 1), 32'd1);
        chk("md_count0", 32'(bus.fifo_count), 32'd0);
        chk("md_we0", 32'(bus.mem_we), 32'd0);
        chk("md_overflow_clr", 32'(bus.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
